// File: rtl/per_router_pkg.sv
// Peripheral bus payload types shared by the arbiter, the router and the slaves.
package per_router_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = DATA_W / 8;

    typedef struct packed {
        logic              mem_valid;
        logic              mem_instr;
        logic [STRB_W-1:0] mem_wstrb;
        logic [ADDR_W-1:0] mem_addr;
        logic [DATA_W-1:0] mem_wdata;
    } mem_in_type;

    typedef struct packed {
        logic              mem_ready;
        logic              mem_error;
        logic [DATA_W-1:0] mem_rdata;
    } mem_out_type;

    localparam mem_in_type  init_mem_in  = '0;
    localparam mem_out_type init_mem_out = '0;

endpackage

// File: rtl/per_router.sv
// Routes the single arbitrated peripheral request to one of NUM_SLV slaves, tracks the
// outstanding transaction, times out silent slaves and filters stray or late responses.
module per_router
    import per_router_pkg::*;
#(
    parameter int unsigned                      NUM_SLV   = 8,
    parameter logic [NUM_SLV-1:0][ADDR_W-1:0]   BASE_ADDR = '0,
    parameter logic [NUM_SLV-1:0][ADDR_W-1:0]   MASK_ADDR = '0,
    parameter int unsigned                      TIMEOUT   = 4096,
    parameter int unsigned                      CNT_WIDTH = 16
) (
    input  logic                         clock,
    input  logic                         reset,
    input  mem_in_type                   per_in,
    output mem_out_type                  per_out,
    output mem_in_type  [NUM_SLV-1:0]    slv_in,
    input  mem_out_type [NUM_SLV-1:0]    slv_out,
    output logic        [NUM_SLV-1:0]    stale,
    output logic                         busy,
    output logic                         proto_err,
    output logic        [CNT_WIDTH-1:0]  timeout_cnt
);

    localparam int unsigned OWN_W  = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
    localparam int unsigned WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam mem_out_type ERR_RSP = '{mem_ready: 1'b1, mem_error: 1'b1, mem_rdata: '0};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ERR  = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [OWN_W-1:0]     owner_q, owner_d;
    logic [WAIT_W-1:0]    wait_cnt_q, wait_cnt_d;
    logic [NUM_SLV-1:0]   stale_q, stale_d;
    logic                 proto_err_q, proto_err_d;
    logic [CNT_WIDTH-1:0] timeout_cnt_q, timeout_cnt_d;

    logic                 hit;
    logic [OWN_W-1:0]     hit_idx;

    // Priority decode: scanning downwards leaves the lowest matching index.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = int'(NUM_SLV) - 1; i >= 0; i--) begin
            if (~|(BASE_ADDR[i] ^ (per_in.mem_addr & ~MASK_ADDR[i]))) begin
                hit     = 1'b1;
                hit_idx = OWN_W'(i);
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        wait_cnt_d    = wait_cnt_q;
        stale_d       = stale_q;
        proto_err_d   = proto_err_q;
        timeout_cnt_d = timeout_cnt_q;
        per_out       = init_mem_out;
        for (int j = 0; j < int'(NUM_SLV); j++) begin
            slv_in[j] = init_mem_in;
        end

        // The first response from an abandoned slave only retires its stale flag.
        for (int j = 0; j < int'(NUM_SLV); j++) begin
            if (slv_out[j].mem_ready) begin
                stale_d[j] = 1'b0;
            end
        end

        case (state_q)
            IDLE: begin
                if (per_in.mem_valid) begin
                    if (hit && !stale_q[hit_idx]) begin
                        slv_in[hit_idx]          = per_in;
                        slv_in[hit_idx].mem_addr = per_in.mem_addr - BASE_ADDR[hit_idx];
                        owner_d                  = hit_idx;
                        wait_cnt_d               = '0;
                        if (slv_out[hit_idx].mem_ready) begin
                            per_out = slv_out[hit_idx];
                        end else begin
                            state_d = BUSY;
                        end
                    end else begin
                        state_d = ERR;
                    end
                end
            end
            ERR: begin
                per_out = ERR_RSP;
                state_d = IDLE;
            end
            BUSY: begin
                if (per_in.mem_valid) begin
                    proto_err_d = 1'b1;
                end
                if (slv_out[owner_q].mem_ready) begin
                    per_out = slv_out[owner_q];
                    state_d = IDLE;
                end else if ((TIMEOUT != 0) && (wait_cnt_q == WAIT_W'(TIMEOUT - 1))) begin
                    per_out          = ERR_RSP;
                    stale_d[owner_q] = 1'b1;
                    if (timeout_cnt_q != '1) begin
                        timeout_cnt_d = timeout_cnt_q + 1'b1;
                    end
                    state_d = IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            owner_q       <= '0;
            wait_cnt_q    <= '0;
            stale_q       <= '0;
            proto_err_q   <= 1'b0;
            timeout_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            wait_cnt_q    <= wait_cnt_d;
            stale_q       <= stale_d;
            proto_err_q   <= proto_err_d;
            timeout_cnt_q <= timeout_cnt_d;
        end
    end

    assign busy        = (state_q == BUSY);
    assign stale       = stale_q;
    assign proto_err   = proto_err_q;
    assign timeout_cnt = timeout_cnt_q;

endmodule

// File: tb/tb_per_router.sv
// Self-checking bench for per_router: directed scenarios followed by random traffic,
// all compared cycle by cycle against a transaction-level reference model.
module tb_per_router;
    import per_router_pkg::*;

    localparam int unsigned N   = 4;
    localparam int unsigned TMO = 8;
    localparam int unsigned CW  = 2;
    localparam logic [N-1:0][31:0] BASE = {32'h0000_0000, 32'h0200_0000, 32'h8000_0000, 32'h0000_0000};
    localparam logic [N-1:0][31:0] MASK = {32'h00FF_FFFF, 32'h0000_FFFF, 32'h0FFF_FFFF, 32'h0000_FFFF};
    localparam mem_out_type ERR_RSP = '{mem_ready: 1'b1, mem_error: 1'b1, mem_rdata: 32'h0};

    logic                  clock = 1'b0;
    logic                  reset;
    mem_in_type            per_in;
    mem_out_type           per_out;
    mem_in_type  [N-1:0]   slv_in;
    mem_out_type [N-1:0]   slv_out;
    logic        [N-1:0]   stale;
    logic                  busy;
    logic                  proto_err;
    logic        [CW-1:0]  timeout_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: one outstanding transaction identified by its start cycle.
    bit         m_busy;
    bit         m_err_pend;
    bit         m_proto;
    int         m_owner;
    int         m_start;
    int         m_tocnt;
    bit [N-1:0] m_stale;
    int         cyc = 0;

    per_router #(
        .NUM_SLV   (N),
        .BASE_ADDR (BASE),
        .MASK_ADDR (MASK),
        .TIMEOUT   (TMO),
        .CNT_WIDTH (CW)
    ) u_dut (
        .clock       (clock),
        .reset       (reset),
        .per_in      (per_in),
        .per_out     (per_out),
        .slv_in      (slv_in),
        .slv_out     (slv_out),
        .stale       (stale),
        .busy        (busy),
        .proto_err   (proto_err),
        .timeout_cnt (timeout_cnt)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int decode(input logic [31:0] a);
        for (int i = 0; i < int'(N); i++) begin
            if ((a & ~MASK[i]) == BASE[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic any_slv_valid();
        logic v = 1'b0;
        for (int i = 0; i < int'(N); i++) v |= slv_in[i].mem_valid;
        return v;
    endfunction

    task automatic model_reset();
        m_busy     = 1'b0;
        m_err_pend = 1'b0;
        m_proto    = 1'b0;
        m_owner    = 0;
        m_start    = 0;
        m_tocnt    = 0;
        m_stale    = '0;
    endtask

    task automatic drive(input bit v, input logic [31:0] a, input logic [N-1:0] rdy, input logic [31:0] rd);
        per_in           = '0;
        per_in.mem_valid = v;
        per_in.mem_addr  = a;
        per_in.mem_wdata = $urandom;
        per_in.mem_wstrb = 4'($urandom);
        for (int i = 0; i < int'(N); i++) begin
            slv_out[i]           = '0;
            slv_out[i].mem_ready = rdy[i];
            slv_out[i].mem_rdata = rd;
        end
    endtask

    // Compare one cycle against the model, advance the model, then move past the next edge.
    task automatic step();
        mem_out_type e_out;
        mem_in_type  e_slv [N];
        bit [N-1:0]  n_stale;
        int          tgt;
        #3;
        check("busy", 512'(busy), 512'(m_busy));
        check("stale", 512'(stale), 512'(m_stale));
        check("proto_err", 512'(proto_err), 512'(m_proto));
        check("timeout_cnt", 512'(timeout_cnt), 512'(m_tocnt));
        e_out = '0;
        for (int i = 0; i < int'(N); i++) e_slv[i] = '0;
        n_stale = m_stale;
        for (int j = 0; j < int'(N); j++) begin
            if (slv_out[j].mem_ready) n_stale[j] = 1'b0;
        end
        if (m_err_pend) begin
            e_out      = ERR_RSP;
            m_err_pend = 1'b0;
        end else if (!m_busy) begin
            if (per_in.mem_valid) begin
                tgt = decode(per_in.mem_addr);
                if (tgt < 0 || m_stale[tgt]) begin
                    m_err_pend = 1'b1;
                end else begin
                    e_slv[tgt]          = per_in;
                    e_slv[tgt].mem_addr = per_in.mem_addr - BASE[tgt];
                    if (slv_out[tgt].mem_ready) begin
                        e_out = slv_out[tgt];
                    end else begin
                        m_busy  = 1'b1;
                        m_owner = tgt;
                        m_start = cyc;
                    end
                end
            end
        end else begin
            if (per_in.mem_valid) m_proto = 1'b1;
            if (slv_out[m_owner].mem_ready) begin
                e_out  = slv_out[m_owner];
                m_busy = 1'b0;
            end else if (cyc - m_start == int'(TMO)) begin
                e_out            = ERR_RSP;
                n_stale[m_owner] = 1'b1;
                if (m_tocnt < (1 << CW) - 1) m_tocnt++;
                m_busy = 1'b0;
            end
        end
        m_stale = n_stale;
        check("per_out", 512'(per_out), 512'(e_out));
        for (int i = 0; i < int'(N); i++) begin
            check($sformatf("slv_in[%0d]", i), 512'(slv_in[i]), 512'(e_slv[i]));
        end
        @(posedge clock);
        #1;
        cyc++;
    endtask

    initial begin
        reset = 1'b0;
        drive(1'b0, 32'h0, '0, 32'h0);
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check("rst_busy", 512'(busy), 512'(1'b0));
        check("rst_stale", 512'(stale), 512'(4'b0000));
        check("rst_per_out", 512'(per_out), 512'(init_mem_out));
        check("rst_tocnt", 512'(timeout_cnt), 512'(2'd0));
        reset = 1'b1;
        step();

        // Routed read answered three cycles later.
        drive(1'b1, 32'h8000_0010, '0, 32'h0);
        #2;
        check("rebase_addr", 512'(slv_in[1].mem_addr), 512'(32'h10));
        check("rebase_valid", 512'(slv_in[1].mem_valid), 512'(1'b1));
        step();
        repeat (2) begin
            drive(1'b0, 32'h0, '0, 32'h0);
            #2;
            check("busy_wait", 512'(busy), 512'(1'b1));
            step();
        end
        drive(1'b0, 32'h0, 4'b0010, 32'hDEAD_BEEF);
        #2;
        check("rd_data", 512'(per_out.mem_rdata), 512'(32'hDEAD_BEEF));
        check("rd_error", 512'(per_out.mem_error), 512'(1'b0));
        check("busy_last", 512'(busy), 512'(1'b1));
        step();
        drive(1'b0, 32'h0, '0, 32'h0);
        #2;
        check("busy_done", 512'(busy), 512'(1'b0));
        step();

        // Overlapping match with a same-cycle responder.
        drive(1'b1, 32'h0000_0004, 4'b0001, 32'h1234_5678);
        #2;
        check("ovl_s0", 512'(slv_in[0].mem_valid), 512'(1'b1));
        check("ovl_s3", 512'(slv_in[3].mem_valid), 512'(1'b0));
        check("comb_rsp", 512'(per_out.mem_rdata), 512'(32'h1234_5678));
        step();

        // Decode miss.
        drive(1'b1, 32'h4000_0000, '0, 32'h0);
        #2;
        check("miss_noreq", 512'(any_slv_valid()), 512'(1'b0));
        check("miss_lat0", 512'(per_out.mem_ready), 512'(1'b0));
        step();
        drive(1'b0, 32'h0, '0, 32'h0);
        #2;
        check("miss_err", 512'(per_out), 512'(ERR_RSP));
        step();
        drive(1'b0, 32'h0, '0, 32'h0);
        #2;
        check("miss_once", 512'(per_out.mem_ready), 512'(1'b0));
        step();

        // Stray responder and illegal request while busy.
        drive(1'b1, 32'h8000_0000, '0, 32'h0);
        step();
        drive(1'b0, 32'h0, 4'b0001, 32'h5555_0000);
        #2;
        check("stray_drop", 512'(per_out.mem_ready), 512'(1'b0));
        step();
        drive(1'b1, 32'h0000_0008, '0, 32'h0);
        #2;
        check("busy_noreq", 512'(any_slv_valid()), 512'(1'b0));
        step();
        drive(1'b0, 32'h0, '0, 32'h0);
        #2;
        check("proto_set", 512'(proto_err), 512'(1'b1));
        step();
        drive(1'b0, 32'h0, 4'b0010, 32'hCAFE_0001);
        #2;
        check("owner_rsp", 512'(per_out.mem_rdata), 512'(32'hCAFE_0001));
        step();
        drive(1'b0, 32'h0, '0, 32'h0);
        #2;
        check("proto_sticky", 512'(proto_err), 512'(1'b1));
        step();

        // Silent slave 2: timeout, stale handling, recovery.
        drive(1'b1, 32'h0200_0004, '0, 32'h0);
        step();
        repeat (TMO - 1) begin
            drive(1'b0, 32'h0, '0, 32'h0);
            step();
        end
        drive(1'b0, 32'h0, '0, 32'h0);
        #2;
        check("to_err", 512'(per_out), 512'(ERR_RSP));
        step();
        drive(1'b0, 32'h0, '0, 32'h0);
        #2;
        check("to_stale", 512'(stale), 512'(4'b0100));
        check("to_cnt", 512'(timeout_cnt), 512'(2'd1));
        step();
        drive(1'b1, 32'h0200_0010, '0, 32'h0);
        #2;
        check("stale_noreq", 512'(any_slv_valid()), 512'(1'b0));
        step();
        drive(1'b0, 32'h0, '0, 32'h0);
        #2;
        check("stale_err", 512'(per_out), 512'(ERR_RSP));
        step();
        drive(1'b0, 32'h0, 4'b0100, 32'hBAD0_0000);
        #2;
        check("late_drop", 512'(per_out.mem_ready), 512'(1'b0));
        step();
        drive(1'b0, 32'h0, '0, 32'h0);
        #2;
        check("stale_clr", 512'(stale), 512'(4'b0000));
        step();
        drive(1'b1, 32'h0200_0020, 4'b0100, 32'h600D_0000);
        #2;
        check("s2_routed", 512'(slv_in[2].mem_valid), 512'(1'b1));
        check("s2_addr", 512'(slv_in[2].mem_addr), 512'(32'h20));
        check("s2_rsp", 512'(per_out.mem_rdata), 512'(32'h600D_0000));
        step();

        // Leave slave 2 stale, then reset in the middle of a transaction.
        drive(1'b1, 32'h0200_0000, '0, 32'h0);
        step();
        repeat (TMO) begin
            drive(1'b0, 32'h0, '0, 32'h0);
            step();
        end
        drive(1'b1, 32'h8000_0040, '0, 32'h0);
        step();
        drive(1'b0, 32'h0, 4'b0010, 32'hABCD_0000);
        #2;
        reset = 1'b0;
        #1;
        check("arst_per_out", 512'(per_out), 512'(init_mem_out));
        check("arst_busy", 512'(busy), 512'(1'b0));
        check("arst_stale", 512'(stale), 512'(4'b0000));
        check("arst_proto", 512'(proto_err), 512'(1'b0));
        check("arst_tocnt", 512'(timeout_cnt), 512'(2'd0));
        model_reset();
        drive(1'b0, 32'h0, '0, 32'h0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        cyc++;
        step();
        drive(1'b1, 32'h8000_0000, '0, 32'h0);
        #2;
        check("post_rst_addr", 512'(slv_in[1].mem_addr), 512'(32'h0));
        check("post_rst_valid", 512'(slv_in[1].mem_valid), 512'(1'b1));
        step();
        drive(1'b0, 32'h0, '0, 32'h0);
        #2;
        check("no_ghost", 512'(per_out.mem_ready), 512'(1'b0));
        step();
        drive(1'b0, 32'h0, 4'b0010, 32'h0000_F00D);
        step();

        // Random traffic; slave 2 is slow enough to time out regularly.
        for (int k = 0; k < 3000; k++) begin
            per_in           = '0;
            per_in.mem_valid = ($urandom_range(0, 99) < 35);
            per_in.mem_instr = 1'($urandom);
            per_in.mem_wstrb = 4'($urandom);
            per_in.mem_wdata = $urandom;
            case ($urandom_range(0, 4))
                0:       per_in.mem_addr = {16'h0000, 16'($urandom)};
                1:       per_in.mem_addr = 32'h8000_0000 | ($urandom & 32'h0FFF_FFFF);
                2:       per_in.mem_addr = {16'h0200, 16'($urandom)};
                3:       per_in.mem_addr = $urandom & 32'h00FF_FFFF;
                default: per_in.mem_addr = $urandom;
            endcase
            for (int i = 0; i < int'(N); i++) begin
                slv_out[i].mem_ready = ($urandom_range(0, 99) < ((i == 2) ? 5 : 25));
                slv_out[i].mem_error = ($urandom_range(0, 7) == 0);
                slv_out[i].mem_rdata = $urandom;
            end
            step();
        end
        check("sat_cnt", 512'(timeout_cnt), 512'(m_tocnt));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
